fixedpoint_acc: RTL and testbench
=================================

FIXEDPOINT_ACC -- requirements
Module: fixedpoint_acc

Interface
REQ-001 Parameter LEN, default 4, sets the number of products summed per frame; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream product on in_data is valid.
REQ-005 in_data  input  8  signed product, the rounded signed 8-bit integer output of the upstream Q4.4 multiplier stage.
REQ-006 in_ready  output  1  block can accept in_data this cycle.
REQ-007 out_valid  output  1  frame sum on out_data is valid.
REQ-008 out_data  output  8  signed frame sum.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_ovf  output  1  frame sum exceeded the signed 8-bit range.

Function
REQ-011 A sample transfers only in a cycle where in_valid and in_ready are both 1; out transfers only where out_valid and out_ready are both 1.
REQ-012 FSM states: IDLE, ACC, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0, acc=0, cnt=0; an accepted sample loads acc=in_data and cnt=1; go to ACC, or to DONE if LEN==1.
REQ-014 ACC: in_ready=1; an accepted sample sets acc=acc+sign-extended in_data and cnt=cnt+1; on acceptance with cnt==LEN-1 go to DONE; no acceptance holds all state.
REQ-015 DONE: in_ready=0, out_valid=1; out_data/out_ovf held stable until out_ready=1, then go to IDLE next cycle.
REQ-016 Latency: out_valid rises the cycle after the LEN-th accepted sample; minimum frame period LEN+1 cycles.
REQ-017 Accumulator width 8+ceil(log2(LEN)) bits signed; internal sum never wraps.
REQ-018 out_ovf=1 when the full-width sum is >127 or <-128; else 0.
REQ-019 in_valid gaps in IDLE/ACC stall accumulation without error; in_data is ignored when in_ready=0.
REQ-020 out_data and out_ovf are registered and change only when entering DONE.

Reset
REQ-021 rst_n low asynchronously forces IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_ovf=0; in_ready=1 after reset release.
REQ-022 Reset mid-frame discards the partial sum; the first accepted sample after release starts a new frame.

Configuration
REQ-023 Macro FXACC_SAT_EN defined: out_data is the full sum clamped to [-128,127].
REQ-024 FXACC_SAT_EN undefined: out_data is the low 8 bits of the full sum (two's-complement wrap); out_ovf still reported.

Structure
REQ-025 Shared package fixedpoint_pkg holds the FSM state enum (IDLE/ACC/DONE), DATA_W=8, and the clamp limits 127/-128.
REQ-026 One sub-module, fxacc_sat (combinational clamp/truncate from acc width to 8 bits), instantiated once.
REQ-027 Target size 120-400 lines of RTL.

Verification (LEN=4)
REQ-028 Sum: 10,20,-5,7 back-to-back, out_ready=1 -> out_data=32, out_ovf=0, out_valid one cycle after the 4th sample.
REQ-029 Positive overflow: 100,100,100,100 -> with FXACC_SAT_EN out_data=127, out_ovf=1; without, out_data=-112 (0x90), out_ovf=1.
REQ-030 Negative extreme: -128 x4 -> with FXACC_SAT_EN out_data=-128, out_ovf=1; without, out_data=0, out_ovf=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid samples not consumed; out_ready=1 -> IDLE next cycle.
REQ-032 Gaps and reset: 2 samples (5,5), in_valid=0 3 cycles, rst_n pulse low, then 1,1,1,1 -> out_data=4, out_ovf=0.

Source files
------------

// File: rtl/fixedpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixedpoint_pkg
// Brief    : Shared types and constants for the fixed-point frame accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package fixedpoint_pkg;

   localparam int DATA_W  = 8;
   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Growth bits are sized so that LEN worst-case products can never wrap.
   function automatic int acc_width(input int len);
      return DATA_W + $clog2(len);
   endfunction

endpackage : fixedpoint_pkg
`default_nettype wire

// File: rtl/fixedpoint_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : fixedpoint_acc_if
// Brief    : Product-in / frame-sum-out handshake bundle for fixedpoint_acc.
// Revision : 1.0 - initial release
// ============================================================================
interface fixedpoint_acc_if;
   import fixedpoint_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              out_ovf;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready,
      output out_ovf
   );

endinterface : fixedpoint_acc_if
`default_nettype wire

// File: rtl/fxacc_sat.sv
`default_nettype none
// ============================================================================
// Module   : fxacc_sat
// Brief    : Reduces a wide signed sum to 8 bits and flags range overflow.
//            FXACC_SAT_EN selects clamping; otherwise two's-complement wrap.
// Revision : 1.0 - initial release
// ============================================================================
module fxacc_sat
   import fixedpoint_pkg::*;
#(
   parameter int ACC_W = 10
)
(
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic        [DATA_W-1:0] o_data,
   output logic                     o_ovf
);

   localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(SAT_MAX);
   localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(SAT_MIN);

   logic w_hi;
   logic w_lo;

   assign w_hi  = (i_acc > c_sat_max);
   assign w_lo  = (i_acc < c_sat_min);
   assign o_ovf = w_hi | w_lo;

`ifdef FXACC_SAT_EN
   always_comb begin
      o_data = i_acc[DATA_W-1:0];
      if (w_hi) begin
         o_data = DATA_W'(SAT_MAX);
      end else if (w_lo) begin
         o_data = DATA_W'(SAT_MIN);
      end
   end
`else
   assign o_data = i_acc[DATA_W-1:0];
`endif

endmodule : fxacc_sat
`default_nettype wire

// File: rtl/fixedpoint_acc.sv
`default_nettype none
// ============================================================================
// Module   : fixedpoint_acc
// Brief    : Sums LEN signed 8-bit products per frame and emits an 8-bit sum
//            with overflow flag. Define FXACC_SAT_EN for a clamped result.
// Revision : 1.0 - initial release
// ============================================================================
module fixedpoint_acc
   import fixedpoint_pkg::*;
#(
   parameter int LEN = 4
)
(
   input  logic           clk,
   input  logic           rst_n,
   fixedpoint_acc_if.slave bus
);

   localparam int c_acc_w = acc_width(LEN);
   localparam int c_cnt_w = $clog2(LEN + 1);

   state_t                     r_state;
   logic signed [c_acc_w-1:0]  r_acc;
   logic        [c_cnt_w-1:0]  r_cnt;
   logic                       r_in_ready;
   logic                       r_out_valid;
   logic        [DATA_W-1:0]   r_out_data;
   logic                       r_out_ovf;

   logic                       w_accept;
   logic                       w_last;
   logic signed [c_acc_w-1:0]  w_in_ext;
   logic signed [c_acc_w-1:0]  w_acc_next;
   logic        [DATA_W-1:0]   w_sat_data;
   logic                       w_sat_ovf;

   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_in_ext   = c_acc_w'($signed(bus.in_data));
   assign w_acc_next = (r_state == IDLE) ? w_in_ext : (r_acc + w_in_ext);
   assign w_last     = (r_state == IDLE) ? (LEN == 1)
                                         : (r_cnt == c_cnt_w'(LEN - 1));

   // Reduction is evaluated on the next sum so the result registers on DONE entry.
   fxacc_sat #(
      .ACC_W (c_acc_w)
   ) u_sat (
      .i_acc  (w_acc_next),
      .o_data (w_sat_data),
      .o_ovf  (w_sat_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, ACC: begin
               if (w_accept) begin
                  r_acc <= w_acc_next;
                  r_cnt <= (r_state == IDLE) ? c_cnt_w'(1) : (r_cnt + c_cnt_w'(1));
                  if (w_last) begin
                     r_state     <= DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_sat_data;
                     r_out_ovf   <= w_sat_ovf;
                  end else begin
                     r_state <= ACC;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ovf   = r_out_ovf;

endmodule : fixedpoint_acc
`default_nettype wire

// File: tb/tb_fixedpoint_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixedpoint_acc
// Brief    : Self-checking bench for fixedpoint_acc (LEN=4), reference model
//            plus directed frames; honours FXACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixedpoint_acc;

   localparam int LEN = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fixedpoint_acc_if bus ();

   fixedpoint_acc #(
      .LEN (LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests  = 0;
   int fails  = 0;
   int frames = 0;

   // Model: frame progress as plain integers; m_data/m_ovf hold the last result.
   bit m_done = 1'b0;
   int m_cnt  = 0;
   int m_sum  = 0;
   int m_data = 0;
   int m_ovf  = 0;

   function automatic int model_out(input int s);
`ifdef FXACC_SAT_EN
      if (s > 127)  return 127;
      if (s < -128) return -128;
      return s;
`else
      int w;
      w = s & 255;
      return (w > 127) ? (w - 256) : w;
`endif
   endfunction

   function automatic int sx(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_sum  <= 0;
         m_data <= 0;
         m_ovf  <= 0;
      end else if (m_done) begin
         if (bus.out_ready) m_done <= 1'b0;
      end else if (bus.in_valid) begin
         if (m_cnt == LEN - 1) begin
            m_done <= 1'b1;
            m_data <= model_out(m_sum + sx(bus.in_data));
            m_ovf  <= ((m_sum + sx(bus.in_data)) > 127 || (m_sum + sx(bus.in_data)) < -128) ? 1 : 0;
            m_cnt  <= 0;
            m_sum  <= 0;
            frames <= frames + 1;
         end else begin
            m_cnt <= m_cnt + 1;
            m_sum <= m_sum + sx(bus.in_data);
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready",  int'(bus.in_ready),  int'(!m_done));
      check("out_valid", int'(bus.out_valid), int'(m_done));
      check("out_data",  sx(bus.out_data),    m_data);
      check("out_ovf",   int'(bus.out_ovf),   m_ovf);
   end

   // Presents v and returns at the falling edge after it was accepted.
   task automatic push(input int v);
      int budget;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(v);
      budget = 0;
      while (bus.in_ready !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) check("push_timeout", 1, 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "bench timed out");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data",  sx(bus.out_data),    0);
      check("rst_out_ovf",   int'(bus.out_ovf),   0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);

      // Back-to-back frame: 10+20-5+7
      push(10); push(20); push(-5); push(7);
      bus.in_valid = 1'b0;
      check("sum_valid", int'(bus.out_valid), 1);
      check("sum_data",  sx(bus.out_data),    32);
      check("sum_ovf",   int'(bus.out_ovf),   0);
      @(negedge clk);
      check("sum_idle_valid", int'(bus.out_valid), 0);
      check("sum_idle_ready", int'(bus.in_ready),  1);

      // Positive overflow held under backpressure
      bus.out_ready = 1'b0;
      push(100); push(100); push(100); push(100);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd55;
`ifdef FXACC_SAT_EN
      check("pos_data", sx(bus.out_data), 127);
`else
      check("pos_data", sx(bus.out_data), -112);
`endif
      check("pos_ovf", int'(bus.out_ovf), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", int'(bus.out_valid), 1);
         check("bp_ready", int'(bus.in_ready),  0);
`ifdef FXACC_SAT_EN
         check("bp_data", sx(bus.out_data), 127);
`else
         check("bp_data", sx(bus.out_data), -112);
`endif
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      check("bp_release_valid", int'(bus.out_valid), 0);

      // Negative extreme
      push(-128); push(-128); push(-128); push(-128);
      bus.in_valid = 1'b0;
`ifdef FXACC_SAT_EN
      check("neg_data", sx(bus.out_data), -128);
`else
      check("neg_data", sx(bus.out_data), 0);
`endif
      check("neg_ovf", int'(bus.out_ovf), 1);
      @(negedge clk);

      // Partial frame, gap, asynchronous reset, fresh frame
      push(5); push(5);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", int'(bus.out_valid), 0);
      check("async_rst_data",  sx(bus.out_data),    0);
      check("async_rst_ready", int'(bus.in_ready),  1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      push(1); push(1); push(1); push(1);
      bus.in_valid = 1'b0;
      check("gap_data", sx(bus.out_data), 4);
      check("gap_ovf",  int'(bus.out_ovf), 0);
      @(negedge clk);

      // Randomized traffic with biased extremes and occasional resets
      for (int n = 0; n < 600; n++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 7))
            0:       bus.in_data = 8'd127;
            1:       bus.in_data = 8'h80;
            2:       bus.in_data = 8'd100;
            default: bus.in_data = 8'($urandom);
         endcase
         bus.out_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("random_frames_seen", int'(frames > 20), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_fixedpoint_acc
`default_nettype wire
